// File: rtl/alu_seq.sv
// Registered ALU with valid/ready handshake, {err,v,c,z} flags and an optional
// multi-cycle shift-add multiplier enabled by defining ALU_SEQ_MUL_EN.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [3:0]       op_sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags
);
    localparam int SW = $clog2(WIDTH);

`ifdef ALU_SEQ_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1, MUL = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd1} state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;

    logic [WIDTH:0]   add_w, sub_w, inc_w;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v, alu_err;

    // Single-cycle datapath for every opcode except the multiplier.
    always_comb begin
        add_w   = {1'b0, op_a} + {1'b0, op_b};
        sub_w   = {1'b0, op_a} - {1'b0, op_b};
        inc_w   = {1'b0, op_a | op_b} + {{WIDTH{1'b0}}, 1'b1};
        shamt   = op_b[SW-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_err = 1'b0;
        case (op_sel)
            4'd0: begin
                alu_res = add_w[WIDTH-1:0];
                alu_c   = add_w[WIDTH];
                alu_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) &&
                          (add_w[WIDTH-1] != op_a[WIDTH-1]);
            end
            4'd1: begin
                alu_res = sub_w[WIDTH-1:0];
                alu_c   = sub_w[WIDTH];
                alu_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) &&
                          (sub_w[WIDTH-1] != op_a[WIDTH-1]);
            end
            4'd3: alu_res = op_a & op_b;
            4'd4: begin
                alu_res = inc_w[WIDTH-1:0];
                alu_c   = inc_w[WIDTH];
            end
            4'd5: alu_res = op_a ^ op_b;
            4'd6: alu_res = ~op_a;
            4'd7: alu_res = op_a << shamt;
            4'd8: alu_res = op_a >> shamt;
            // Opcode 2 lands here too; with the multiplier built it never
            // reaches this result because the FSM diverts it to MUL.
            default: alu_err = 1'b1;
        endcase
    end

`ifdef ALU_SEQ_MUL_EN
    localparam int CW = (SW < 1) ? 1 : SW;

    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_next;

    assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
`ifdef ALU_SEQ_MUL_EN
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        mplier_d = mplier_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
`ifdef ALU_SEQ_MUL_EN
                    if (op_sel == 4'd2) begin
                        mcand_d  = {{WIDTH{1'b0}}, op_a};
                        mplier_d = op_b;
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else
`endif
                    begin
                        result_d = alu_res;
                        flags_d  = {alu_err, alu_v, alu_c, (alu_res == '0)};
                        state_d  = DONE;
                    end
                end
            end
`ifdef ALU_SEQ_MUL_EN
            MUL: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                // Last partial product is folded in combinationally so the
                // product is registered on exactly the WIDTH-th MUL edge.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d    = '0;
                    result_d = acc_next[WIDTH-1:0];
                    flags_d  = {2'b00, (acc_next[2*WIDTH-1:WIDTH] != '0),
                                (acc_next[WIDTH-1:0] == '0)};
                    state_d  = DONE;
                end
            end
`endif
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
`ifdef ALU_SEQ_MUL_EN
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
`ifdef ALU_SEQ_MUL_EN
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            mplier_q <= mplier_d;
`endif
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: stimulus pushes model results, a monitor pops
// and compares on every presented output. Follows ALU_SEQ_MUL_EN like the RTL.
module tb_alu_seq;
    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic [3:0]   op_sel = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic [3:0]   flags;

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .op_sel(op_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   fl;
        int           acc;
        int           dly;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   rdy_mode = 0;  // 0: ready high, 1: ready low, 2: random

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    // Reference built from the opcode table with plain integer arithmetic.
    function automatic exp_t model(input int a, input int b, input int op);
        exp_t   m;
        int     msk, half, sa, sb, t, r;
        longint p;
        logic   c, v, e;
        msk  = (1 << W) - 1;
        half = 1 << (W - 1);
        sa   = (a >= half) ? a - (1 << W) : a;
        sb   = (b >= half) ? b - (1 << W) : b;
        r = 0; c = 1'b0; v = 1'b0; e = 1'b0; m.dly = 0;
        case (op)
            0: begin t = a + b; r = t & msk; c = (t > msk);
                     v = ((sa + sb) > half - 1) || ((sa + sb) < -half); end
            1: begin t = a - b; r = t & msk; c = (a < b);
                     v = ((sa - sb) > half - 1) || ((sa - sb) < -half); end
`ifdef ALU_SEQ_MUL_EN
            2: begin p = longint'(a) * longint'(b); r = int'(p & longint'(msk));
                     c = ((p >> W) != 0); m.dly = W; end
`endif
            3: r = a & b;
            4: begin t = (a | b) + 1; r = t & msk; c = (t > msk); end
            5: r = a ^ b;
            6: r = ~a & msk;
            7: r = (a << (b % W)) & msk;
            8: r = a >> (b % W);
            default: e = 1'b1;
        endcase
        m.res = r[W-1:0];
        m.fl  = {e, v, c, (r == 0)};
        m.acc = 0;
        return m;
    endfunction

    initial forever begin
        @(posedge clk);
        #2;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = 1'b0;
            default: out_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    // Monitor: compares front of queue whenever a result is presented.
    initial begin
        logic prev_v;
        prev_v = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_v = 1'b0;
            end else begin
                if (out_valid) begin
                    if (sbq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_out actual=valid required=idle (cycle %0d)", cyc);
                    end else begin
                        if (!prev_v) chk("latency", cyc - sbq[0].acc, sbq[0].dly);
                        chk("result", int'(result), int'(sbq[0].res));
                        chk("flags", int'(flags), int'(sbq[0].fl));
                        chk("in_ready_in_done", int'(in_ready), 0);
                        if (out_ready) void'(sbq.pop_front());
                    end
                end
                prev_v = out_valid;
            end
        end
    end

    task automatic issue(input int a, input int b, input int op);
        exp_t m;
        int   n;
        @(negedge clk);
        op_a = a[W-1:0]; op_b = b[W-1:0]; op_sel = op[3:0]; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 0, 1);
            in_valid = 1'b0;
        end else begin
            m = model(a, b, op);
            m.acc = cyc + 1;
            sbq.push_back(m);
            @(negedge clk);
            in_valid = 1'b0;
            op_a = W'($urandom); op_b = W'($urandom); op_sel = 4'($urandom);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || out_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", sbq.size(), 0);
    endtask

    initial begin
        int n;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_flags", int'(flags), 0);
        rst_n = 1'b1;

        rdy_mode = 0;
        issue('hF0, 'h20, 0);
        issue('h80, 'h01, 1);
        issue('h01, 'h02, 1);
        issue('h10, 'h11, 2);
        issue('hFF, 'h00, 4);
        issue('h80, 'h0B, 8);
        issue('h00, 'h00, 'hC);
        issue('h81, 'h03, 7);
        issue('h5A, 'h00, 6);
        drain();

        // Stall: result must hold while in_valid pulses are ignored.
        rdy_mode = 1;
        repeat (2) @(negedge clk);
        issue('h03, 'h04, 0);
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("stall_valid_seen", int'(out_valid), 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i % 2 == 0);
            op_a = W'($urandom); op_b = W'($urandom); op_sel = 4'd0;
        end
        in_valid = 1'b0;
        rdy_mode = 0;
        n = 0;
        while (!(out_valid && out_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk("release_in_ready", int'(in_ready), 1);
        chk("release_out_valid", int'(out_valid), 0);
        chk("stall_pulses_ignored", sbq.size(), 0);

        // Reset while an operation is in flight (MUL, or DONE without it).
        rdy_mode = 1;
        issue('h05, 'h06, 2);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_result", int'(result), 0);
        chk("midrst_flags", int'(flags), 0);
        chk("midrst_in_ready", int'(in_ready), 1);
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 0;
        issue('h01, 'h01, 0);
        drain();

        rdy_mode = 2;
        repeat (60) issue(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                          int'($urandom_range(0, 11)));
        rdy_mode = 0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised-width ALU with a valid/ready handshake on input and output, status flags, and a multi-cycle shift-add multiplier. It is the sequential successor to the team's 8-bit combinational ALU. It keeps that ALU's opcode encodings 0–6 and adds shifts, flags and illegal-opcode reporting. It sits between an operand source (register file or FPGA test harness) and a result consumer, and handles one operation at a time.

## Interface
- WIDTH, 8, operand/result width in bits (≥2)
- clk  input  1  sole clock, rising edge
- rst_n  input  1  reset; asynchronous, active-low
- in_valid  input  1  op_a/op_b/op_sel valid
- in_ready  output  1  block can accept an operation
- op_a  input  WIDTH  operand A
- op_b  input  WIDTH  operand B
- op_sel  input  4  opcode
- out_valid  output  1  result/flags valid
- out_ready  input  1  consumer takes result
- result  output  WIDTH  registered result
- flags  output  4  {err, v, c, z}

## Operation
- Opcodes (all arithmetic mod 2^WIDTH):
  - 0: A+B
  - 1: A−B
  - 2: A*B, low WIDTH bits
  - 3: A&B
  - 4: (A|B)+1 (kept for compatibility)
  - 5: A^B
  - 6: ~A
  - 7: A << B[log2(WIDTH)−1:0]
  - 8: A >> B[log2(WIDTH)−1:0], logical
  - 9–15: illegal; result 0, err=1
- Flags:
  - z = (result == 0).
  - c:
    - op0: carry out.
    - op1: borrow (A < B unsigned).
    - op2: high half of the full 2·WIDTH product ≠ 0.
    - op4: carry out of the +1.
    - All other ops: 0.
  - v: signed overflow for op0/op1; 0 for all other ops.
  - err: 1 only for illegal opcodes.
- FSM states: IDLE, MUL, DONE.
  - IDLE: in_ready=1. On in_valid:
    - op_sel==2: latch operands, cnt=0, go to MUL.
    - Any other opcode: compute, register result/flags, go to DONE.
  - MUL: one shift-add step per cycle, cnt++. When cnt==WIDTH−1: register product/flags, go to DONE.
  - DONE: out_valid=1. result/flags held stable until out_ready=1, then go to IDLE.
- in_ready = (state==IDLE); out_valid = (state==DONE). Neither is combinationally dependent on in_valid/out_ready.
- Inputs are sampled only at the acceptance edge; later changes to op_a/op_b/op_sel have no effect.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, result=0, flags=0, cnt=0.
- Acceptance edge E0 = rising edge with in_valid && in_ready.
- Non-multiply latency: out_valid high in the cycle after E0.
- Multiply latency: out_valid rises after edge E0+WIDTH (WIDTH=8: 8 cycles after acceptance).
- Throughput, non-multiply with out_ready held high: one result every 2 cycles. A DONE cycle with out_ready=1 is followed by IDLE; no same-cycle re-accept.
- out_ready low in DONE: stall indefinitely; outputs unchanged.
- in_valid during MUL/DONE: ignored (in_ready=0); the source must hold it.
- rst_n asserted mid-MUL or in DONE: immediately return to reset values; the in-flight operation is discarded.
- Releasing rst_n: first acceptance possible at the first rising edge after release.

## Configuration
- ALU_SEQ_MUL_EN defined: opcode 2 uses the MUL state as above.
- ALU_SEQ_MUL_EN undefined:
  - No multiplier or MUL state is built.
  - Opcode 2 is treated as illegal: 1-cycle latency, result 0, flags err=1, z=1.

## Test plan
- WIDTH=8, op0, A=0xF0, B=0x20 → one cycle later out_valid=1, result=0x10, c=1, v=0, z=0.
- op1, A=0x80, B=0x01 → result=0x7F, c=0, v=1; then op1, A=0x01, B=0x02 → result=0xFF, c=1.
- op2, A=0x10, B=0x11 (MUL_EN) → out_valid rises 8 cycles after acceptance, result=0x10, c=1; in_ready=0 throughout.
- op4, A=0xFF, B=0x00 → result=0x00, z=1, c=1. op8, A=0x80, B=0x0B → shift by 3, result=0x10. op_sel=0xC → result=0x00, err=1.
- Hold out_ready=0 for 5 cycles after an op0 result → result/flags/out_valid stable; in_valid pulses ignored; release → IDLE next cycle.
- Assert rst_n low 3 cycles into a multiply → out_valid=0, result=0, flags=0, in_ready=1 immediately; next op0 (A=1, B=1) → result=0x02.
